// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift-register link (PISO transmitter and SIPO receiver).
// Holds the FSM state encoding, the default word width and the frame-length helper.
package shift_reg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32'd4;

  // A frame is the data bits, plus one trailing parity bit when parity is enabled.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    int unsigned len;
    if (parity_en) begin
      len = width + 32'd1;
    end else begin
      len = width;
    end
    return len;
  endfunction

endpackage

// File: rtl/shift_reg_piso_tx_if.sv
// Word-in / bit-out bundle of the PISO transmitter.
// The master is the word source and serial-link observer; the slave is the transmitter.
interface shift_reg_piso_tx_if
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, sdo, sdo_valid, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sdo, sdo_valid, busy, done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable up-counter that tracks the bit position inside a serial frame.
// tc flags that the count has reached TERM, which is the last bit of the frame.
module piso_bit_counter #(
  parameter int unsigned       CNT_W = 32'd3,
  parameter logic [CNT_W-1:0]  TERM  = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load clears to the first bit position and takes priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TERM);

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in/serial-out transmitter: sends an accepted word MSB-first, one bit per clk.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module shift_reg_piso_tx
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_reg_piso_tx_if.slave   bus
);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int unsigned      FRAME_LEN = frame_len(WIDTH, PARITY_EN);
  localparam int unsigned      CNT_W     = $clog2(WIDTH + 32'd1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN - 32'd1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             sdo_q;
  logic             sdo_d;
  logic             sdo_valid_q;
  logic             sdo_valid_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tc_s;
  logic             cnt_load_s;
  logic             cnt_inc_s;
  logic             din_ready_s;
  logic             accept_s;

`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);

  logic parity_q;
  logic parity_d;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  piso_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (LAST_CNT)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load_s),
    .inc   (cnt_inc_s),
    .cnt   (cnt_s),
    .tc    (tc_s)
  );

  // Ready while idle, and on the last bit of a frame so a new word can follow with no gap.
  assign din_ready_s = (state_q == ST_IDLE) || tc_s;
  assign accept_s    = bus.din_valid && din_ready_s;
  assign cnt_nxt_s   = cnt_s + CNT_W'(1);

  // Next state and next registered outputs; each flop holds the value shown in the following cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sdo_d       = IDLE_LEVEL;
    sdo_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept_s) begin
      state_d     = ST_SHIFT;
      shreg_d     = bus.din;
      sdo_d       = bus.din[WIDTH-1];
      sdo_valid_d = 1'b1;
      busy_d      = 1'b1;
      cnt_load_s  = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d    = even_parity(bus.din);
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (tc_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_SHIFT;
            cnt_inc_s   = 1'b1;
            // Rotate rather than shift so the register never drops bits it still owns.
            shreg_d     = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            sdo_d       = shreg_q[WIDTH-2];
            sdo_valid_d = 1'b1;
            busy_d      = 1'b1;
            done_d      = (cnt_nxt_s == LAST_CNT);
`ifdef PISO_PARITY_EN
            if (cnt_nxt_s == PAR_CNT) begin
              sdo_d = parity_q;
            end else begin
              sdo_d = shreg_q[WIDTH-2];
            end
`endif
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, shifter and output registers; reset aborts any frame in flight at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      sdo_q       <= IDLE_LEVEL;
      sdo_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  // Parity of the word being sent, captured at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign bus.din_ready = din_ready_s;
  assign bus.sdo       = sdo_q;
  assign bus.sdo_valid = sdo_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Randomised and directed bench for shift_reg_piso_tx against a bit-queue frame model,
// with a behavioural SIPO on the serial output to confirm words reassemble.
module tb_shift_reg_piso_tx;
  import shift_reg_pkg::*;

  localparam int   W    = 4;
  localparam logic IDLE = 1'b0;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  shift_reg_piso_tx_if #(.WIDTH(W)) bus ();

  shift_reg_piso_tx #(
    .WIDTH      (W),
    .IDLE_LEVEL (IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: the bit on the wire this cycle plus the bits still to come in the frame.
  bit         m_valid = 1'b0;
  bit         m_done  = 1'b0;
  logic       m_sdo   = IDLE;
  bit         m_acc   = 1'b0;
  bit         m_q[$];
  logic [W-1:0] active_tail = '0;
  logic [W-1:0] done_tail   = '0;
  bit         tail_pending = 1'b0;
  logic [W-1:0] sipo = '0;
  logic       prev_sdo   = 1'b0;
  logic       prev_valid = 1'b0;

  function automatic bit model_ready();
    return !m_valid || m_done;
  endfunction

  task automatic compare_outputs();
    check_eq("din_ready", 32'(bus.din_ready), 32'(model_ready()));
    check_eq("sdo",       32'(bus.sdo),       32'(m_sdo));
    check_eq("sdo_valid", 32'(bus.sdo_valid), 32'(m_valid));
    check_eq("busy",      32'(bus.busy),      32'(m_valid));
    check_eq("done",      32'(bus.done),      32'(m_done));
  endtask

  task automatic tick();
    logic [W-1:0] w;
    @(posedge clk);
    if (prev_valid) sipo = {sipo[W-2:0], prev_sdo};
    if (tail_pending) begin
      check_eq("loopback", 32'(sipo), 32'(done_tail));
      tail_pending = 1'b0;
    end
    m_acc = 1'b0;
    if (reset) begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_sdo   = IDLE;
      m_q.delete();
    end else begin
      if (bus.din_valid && model_ready()) begin
        m_acc = 1'b1;
        w = bus.din;
        m_q.delete();
        for (int i = W - 1; i >= 0; i--) m_q.push_back(w[i]);
        if (PAR) begin
          m_q.push_back(^w);
          active_tail = {w[W-2:0], ^w};
        end else begin
          active_tail = w;
        end
        m_sdo   = m_q.pop_front();
        m_valid = 1'b1;
      end else if (m_q.size() > 0) begin
        m_sdo = m_q.pop_front();
      end else begin
        m_valid = 1'b0;
        m_sdo   = IDLE;
      end
      m_done = m_valid && (m_q.size() == 0);
      if (m_done) begin
        done_tail    = active_tail;
        tail_pending = 1'b1;
      end
    end
    #1;
    compare_outputs();
    prev_sdo   = bus.sdo;
    prev_valid = bus.sdo_valid;
  endtask

  // Called just after a clock edge: reset must clear the outputs with no edge in between.
  task automatic apply_async_reset();
    reset = 1'b1;
    #2;
    check_eq("rst_sdo",       32'(bus.sdo),       32'(IDLE));
    check_eq("rst_sdo_valid", 32'(bus.sdo_valid), 32'(1'b0));
    check_eq("rst_busy",      32'(bus.busy),      32'(1'b0));
    check_eq("rst_done",      32'(bus.done),      32'(1'b0));
    check_eq("rst_din_ready", 32'(bus.din_ready), 32'(1'b1));
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_sdo   = IDLE;
    m_q.delete();
    tail_pending = 1'b0;
    prev_sdo     = bus.sdo;
    prev_valid   = bus.sdo_valid;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_acc) return;
    end
    check_eq("accept_timeout", 32'(m_acc), 32'(1'b1));
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.din = W'($urandom);
      tick();
    end
  endtask

  initial begin
    bit holding;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    apply_async_reset();
    idle(2);

    send_word(4'b1011);
    idle(6);

    send_word(4'b1000);
    send_word(4'b0001);
    idle(6);

    send_word(4'b0101);
    bus.din_valid = 1'b0;
    tick();
    send_word(4'b1111);
    idle(6);

    send_word(4'b1101);
    bus.din_valid = 1'b0;
    tick();
    apply_async_reset();
    send_word(4'b0110);
    idle(6);

    send_word(4'b1001);
    idle(6);

    for (int i = 0; i < 600; i++) begin
      holding = bus.din_valid && !m_acc;
      if (!holding) begin
        bus.din_valid = ($urandom_range(0, 3) != 0);
        bus.din       = W'($urandom);
      end
      if ($urandom_range(0, 79) == 0) begin
        apply_async_reset();
      end else begin
        tick();
      end
    end
    idle(8);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
